// File: rtl/pedal_pkg.sv
// Shared types and helpers for the multi-tap delay / looper.
// Holds FSM states, loop-mode codes and the saturating clamp.
package pedal_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_READ,
        ST_DRAIN,
        ST_WRITE
    } state_t;

    localparam logic [1:0] LOOP_DELAY = 2'b00;
    localparam logic [1:0] LOOP_REC   = 2'b01;
    localparam logic [1:0] LOOP_PLAY  = 2'b10;

    localparam int GAIN_ONE = 128;

    function automatic logic signed [63:0] saturate(
        input logic signed [63:0] v,
        input int                 w
    );
        logic signed [63:0] hi;
        logic signed [63:0] lo;
        hi = (64'sd1 <<< (w - 1)) - 64'sd1;
        lo = -(64'sd1 <<< (w - 1));
        if (v > hi) return hi;
        if (v < lo) return lo;
        return v;
    endfunction

endpackage

// File: rtl/pedal_tap_mac.sv
// Shared multiply-accumulate for all taps: acc += (sample * gain) >>> (GAIN_W-1).
// sum exposes the post-add value so the final tap can be used the same cycle.
module pedal_tap_mac #(
    parameter int DATA_W = 16,
    parameter int GAIN_W = 8,
    parameter int ACC_W  = 27
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     clr,
    input  logic                     en,
    input  logic signed [DATA_W-1:0] sample,
    input  logic [GAIN_W-1:0]        gain,
    output logic signed [ACC_W-1:0]  sum
);
    logic signed [DATA_W+GAIN_W:0] prod;
    logic signed [DATA_W+GAIN_W:0] shf;
    logic signed [ACC_W-1:0]       term;
    logic signed [ACC_W-1:0]       acc;

    assign prod = sample * $signed({1'b0, gain});
    assign shf  = prod >>> (GAIN_W - 1);
    assign term = ACC_W'(shf);
    assign sum  = en ? acc + term : acc;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc <= '0;
        end else if (clr) begin
            acc <= '0;
        end else if (en) begin
            acc <= sum;
        end
    end

endmodule

// File: rtl/pedal_multitap_delay.sv
// Multi-tap SRAM delay with feedback; one tap read per cycle, then write-back.
// Optional looper (record/play) when PEDAL_LOOPER_EN is defined.
module pedal_multitap_delay
    import pedal_pkg::*;
#(
    parameter int DATA_W   = 16,
    parameter int ADDR_W   = 15,
    parameter int NUM_TAPS = 4,
    parameter int GAIN_W   = 8
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       sample_valid,
    input  logic signed [DATA_W-1:0]   sample_in,
    input  logic [NUM_TAPS*ADDR_W-1:0] tap_delay,
    input  logic [NUM_TAPS*GAIN_W-1:0] tap_gain,
    input  logic [GAIN_W-1:0]          fb_gain,
    input  logic                       bypass,
    input  logic                       clear_overrun,
    output logic                       mem_csb,
    output logic                       mem_web,
    output logic [ADDR_W-1:0]          mem_addr,
    output logic signed [DATA_W-1:0]   mem_din,
    input  logic signed [DATA_W-1:0]   mem_dout,
    output logic signed [DATA_W-1:0]   sample_out,
    output logic                       out_valid,
    output logic                       busy,
    output logic                       overrun
`ifdef PEDAL_LOOPER_EN
    ,
    input  logic [1:0]                 loop_mode,
    output logic [ADDR_W-1:0]          loop_len
`endif
);
    localparam int ACC_W = DATA_W + GAIN_W + $clog2(NUM_TAPS) + 1;
    localparam int IDX_W = (NUM_TAPS > 1) ? $clog2(NUM_TAPS) : 1;
    localparam logic [GAIN_W-1:0] UNITY = GAIN_W'(1 << (GAIN_W - 1));

    state_t                     state;
    logic [IDX_W-1:0]           idx;
    logic [ADDR_W-1:0]          wr_ptr;
    logic [ADDR_W-1:0]          play_ptr;
    logic [ADDR_W-1:0]          len_q;
    logic [NUM_TAPS*ADDR_W-1:0] dly_q;
    logic [NUM_TAPS*GAIN_W-1:0] gain_q;
    logic [GAIN_W-1:0]          fb_q;
    logic [GAIN_W-1:0]          show_gain;
    logic [GAIN_W-1:0]          pend_gain;
    logic signed [DATA_W-1:0]   dry_q;
    logic                       byp_q;
    logic                       show_rd;
    logic                       pend_en;
    logic [1:0]                 mode_in;
    logic [1:0]                 mode_q;
    logic signed [ACC_W-1:0]    acc_next;

`ifdef PEDAL_LOOPER_EN
    assign mode_in  = loop_mode;
    assign loop_len = len_q;
`else
    assign mode_in  = LOOP_DELAY;
`endif

    pedal_tap_mac #(
        .DATA_W(DATA_W),
        .GAIN_W(GAIN_W),
        .ACC_W (ACC_W)
    ) u_mac (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (state == ST_IDLE),
        .en    (pend_en),
        .sample(mem_dout),
        .gain  (pend_gain),
        .sum   (acc_next)
    );

    // Address/enable of the tap to present on the next cycle.
    int                nxt;
    logic [1:0]        cur_mode;
    logic [ADDR_W-1:0] cur_dly;
    logic [GAIN_W-1:0] cur_gain;
    logic [GAIN_W-1:0] cur_geff;
    logic [ADDR_W-1:0] cur_addr;
    logic [ADDR_W-1:0] base_wr;
    logic [ADDR_W-1:0] base_play;
    logic              cur_rd;
    logic              enter_rec;
    logic              leave_rec;

    always_comb begin
        nxt = (state == ST_READ) ? int'(idx) + 1 : 0;
        if (nxt >= NUM_TAPS) nxt = 0;
        if (state == ST_IDLE) begin
            cur_mode = mode_in;
            cur_dly  = tap_delay[nxt*ADDR_W +: ADDR_W];
            cur_gain = tap_gain[nxt*GAIN_W +: GAIN_W];
        end else begin
            cur_mode = mode_q;
            cur_dly  = dly_q[nxt*ADDR_W +: ADDR_W];
            cur_gain = gain_q[nxt*GAIN_W +: GAIN_W];
        end
        enter_rec = (state == ST_IDLE) && (mode_in == LOOP_REC)
                  && (mode_q != LOOP_REC);
        leave_rec = (state == ST_IDLE) && (mode_in != LOOP_REC)
                  && (mode_q == LOOP_REC);
        base_wr   = (enter_rec || leave_rec) ? '0 : wr_ptr;
        base_play = leave_rec ? '0 : play_ptr;
        cur_rd    = 1'b0;
        cur_geff  = cur_gain;
        cur_addr  = base_wr - cur_dly;
        unique case (1'b1)
            (cur_mode == LOOP_DELAY): begin
                cur_rd = (cur_dly != '0) && (cur_gain != '0);
            end
            (cur_mode == LOOP_PLAY): begin
                cur_rd   = (nxt == 0) && (len_q != '0);
                cur_addr = base_play;
                cur_geff = UNITY;
            end
            default: cur_rd = 1'b0;
        endcase
    end

    logic signed [63:0]       wet_w;
    logic signed [63:0]       dry_w;
    logic signed [63:0]       fb_w;
    logic signed [DATA_W-1:0] mix;
    logic signed [DATA_W-1:0] echo;
    logic                     pass_dry;

    assign wet_w    = 64'(acc_next);
    assign dry_w    = 64'(dry_q);
    assign fb_w     = (wet_w * $signed(64'(fb_q))) >>> (GAIN_W - 1);
    assign mix      = DATA_W'(saturate(dry_w + wet_w, DATA_W));
    assign echo     = DATA_W'(saturate(dry_w + fb_w, DATA_W));
    assign pass_dry = byp_q || (mode_q == LOOP_REC);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= ST_IDLE;
            idx        <= '0;
            wr_ptr     <= '0;
            play_ptr   <= '0;
            len_q      <= '0;
            dly_q      <= '0;
            gain_q     <= '0;
            fb_q       <= '0;
            dry_q      <= '0;
            byp_q      <= 1'b0;
            mode_q     <= LOOP_DELAY;
            show_rd    <= 1'b0;
            show_gain  <= '0;
            pend_en    <= 1'b0;
            pend_gain  <= '0;
            mem_csb    <= 1'b1;
            mem_web    <= 1'b1;
            mem_addr   <= '0;
            mem_din    <= '0;
            sample_out <= '0;
            out_valid  <= 1'b0;
            busy       <= 1'b0;
        end else begin
            pend_en   <= (state == ST_READ) && show_rd;
            pend_gain <= show_gain;
            out_valid <= 1'b0;
            unique case (state)
                ST_IDLE: begin
                    if (sample_valid) begin
                        dry_q     <= sample_in;
                        dly_q     <= tap_delay;
                        gain_q    <= tap_gain;
                        fb_q      <= fb_gain;
                        byp_q     <= bypass;
                        mode_q    <= mode_in;
                        wr_ptr    <= base_wr;
                        play_ptr  <= base_play;
                        if (enter_rec) len_q <= '0;
                        idx       <= '0;
                        busy      <= 1'b1;
                        state     <= ST_READ;
                        mem_csb   <= !cur_rd;
                        mem_web   <= 1'b1;
                        mem_addr  <= cur_addr;
                        show_rd   <= cur_rd;
                        show_gain <= cur_geff;
                    end
                end
                ST_READ: begin
                    if (int'(idx) == NUM_TAPS - 1) begin
                        state   <= ST_DRAIN;
                        mem_csb <= 1'b1;
                        show_rd <= 1'b0;
                    end else begin
                        idx       <= idx + IDX_W'(1);
                        mem_csb   <= !cur_rd;
                        mem_addr  <= cur_addr;
                        show_rd   <= cur_rd;
                        show_gain <= cur_geff;
                    end
                end
                ST_DRAIN: begin
                    state      <= ST_WRITE;
                    out_valid  <= 1'b1;
                    sample_out <= pass_dry ? dry_q : mix;
                    if (mode_q != LOOP_PLAY) begin
                        mem_csb  <= 1'b0;
                        mem_web  <= 1'b0;
                        mem_addr <= wr_ptr;
                        mem_din  <= pass_dry ? dry_q : echo;
                    end
                end
                ST_WRITE: begin
                    state   <= ST_IDLE;
                    busy    <= 1'b0;
                    mem_csb <= 1'b1;
                    mem_web <= 1'b1;
                    if (mode_q == LOOP_PLAY) begin
                        play_ptr <= (play_ptr + ADDR_W'(1) == len_q)
                                  ? '0 : play_ptr + ADDR_W'(1);
                    end else begin
                        wr_ptr <= wr_ptr + ADDR_W'(1);
                    end
                    if (mode_q == LOOP_REC && len_q != '1) begin
                        len_q <= len_q + ADDR_W'(1);
                    end
                end
            endcase
        end
    end

    // A strobe while busy is dropped; a set beats a simultaneous clear.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            overrun <= 1'b0;
        end else if (sample_valid && state != ST_IDLE) begin
            overrun <= 1'b1;
        end else if (clear_overrun) begin
            overrun <= 1'b0;
        end
    end

endmodule
